// File: rtl/btn_pkg.sv
// Shared types and timing constants for push-button conditioning.
// Cycle counts assume the 125 MHz fabric clock.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } btn_state_t;

    localparam int unsigned CYC_10MS_125M = 1250000;
    localparam int unsigned CYC_1S_125M   = 125000000;

    function automatic int unsigned max_u(
        input int unsigned a,
        input int unsigned b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for one asynchronous input bit.
// Shared by every async pin entering the fabric clock domain.
module bit_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    if (STAGES < 2) begin : g_bad_stages
        $fatal(1, "bit_sync: STAGES must be >= 2");
    end

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Push-button front end: synchronize, debounce, and derive
// press/release pulses, a toggle state and a long-press flag.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = CYC_10MS_125M,
    parameter int unsigned HOLD_CYCLES   = CYC_1S_125M
) (
    input  logic clk125_i,
    input  logic reset,
    input  logic btn_raw_i,
    output logic btn_level_out,
    output logic btn_press_out,
    output logic btn_release_out,
    output logic btn_toggle_out,
    output logic btn_hold_out
);

    localparam int unsigned CNT_W =
        $clog2(max_u(STABLE_CYCLES, HOLD_CYCLES) + 1);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX    = CNT_W'(HOLD_CYCLES);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "btn_debounce: SYNC_STAGES must be >= 2");
    end
    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $fatal(1, "btn_debounce: STABLE_CYCLES must be >= 2");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $fatal(1, "btn_debounce: HOLD_CYCLES must be >= 1");
    end

    logic             w_sync_q;
    btn_state_t       r_state;
    btn_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] w_hold_nxt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             r_toggle;
    logic             w_level_nxt;
    logic             w_rise;
    logic             w_fall;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (clk125_i),
        .i_reset (reset),
        .i_d     (btn_raw_i),
        .o_q     (w_sync_q)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE_LOW: begin
                if (w_sync_q) begin
                    w_state_nxt = WAIT_HIGH;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            WAIT_HIGH: begin
                if (!w_sync_q) begin
                    w_state_nxt = IDLE_LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_nxt = IDLE_HIGH;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!w_sync_q) begin
                    w_state_nxt = WAIT_LOW;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            WAIT_LOW: begin
                if (w_sync_q) begin
                    w_state_nxt = IDLE_HIGH;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_nxt = IDLE_LOW;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
        endcase
    end

    // Level follows the next state so all outputs move on the accept edge.
    always_comb begin
        w_level_nxt = (w_state_nxt == IDLE_HIGH) || (w_state_nxt == WAIT_LOW);
        w_rise      = w_level_nxt && !r_level;
        w_fall      = !w_level_nxt && r_level;
        w_hold_nxt  = r_hold_cnt;
        if (!w_level_nxt) begin
            w_hold_nxt = '0;
        end else if (r_level && (r_hold_cnt != HOLD_MAX)) begin
            w_hold_nxt = r_hold_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk125_i) begin
        if (reset) begin
            r_state    <= IDLE_LOW;
            r_cnt      <= '0;
            r_hold_cnt <= '0;
            r_level    <= 1'b0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_toggle   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_level    <= w_level_nxt;
            r_press    <= w_rise;
            r_release  <= w_fall;
            r_toggle   <= r_toggle ^ w_rise;
        end
    end

    assign btn_level_out   = r_level;
    assign btn_press_out   = r_press;
    assign btn_release_out = r_release;
    assign btn_toggle_out  = r_toggle;
    assign btn_hold_out    = (r_hold_cnt == HOLD_MAX);

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed latency checks plus random
// bouncing stimulus compared every cycle against a window model.
module tb_btn_debounce;

    localparam int SYNC_N = 2;
    localparam int STAB_N = 8;
    localparam int HOLD_N = 32;
    localparam int HIST   = SYNC_N + STAB_N;

    logic clk = 1'b0;
    logic reset;
    logic btn_raw;
    logic o_level;
    logic o_press;
    logic o_release;
    logic o_toggle;
    logic o_hold;

    int checks = 0;
    int errors = 0;

    always #4 clk = ~clk;

    btn_debounce #(
        .SYNC_STAGES   (SYNC_N),
        .STABLE_CYCLES (STAB_N),
        .HOLD_CYCLES   (HOLD_N)
    ) dut (
        .clk125_i        (clk),
        .reset           (reset),
        .btn_raw_i       (btn_raw),
        .btn_level_out   (o_level),
        .btn_press_out   (o_press),
        .btn_release_out (o_release),
        .btn_toggle_out  (o_toggle),
        .btn_hold_out    (o_hold)
    );

    task automatic check(
        input string       name,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: raw_hist[i] is the raw sample taken i edges ago; the FSM
    // sees raw delayed by SYNC_N, and a level is accepted once the
    // last STAB_N delayed samples all disagree with the current level.
    logic [HIST-1:0] raw_hist;
    logic m_valid = 1'b0;
    logic m_level, m_press, m_release, m_toggle, m_hold;
    int   m_high_edges;

    always @(posedge clk) begin
        logic prev;
        if (reset) begin
            raw_hist     = '0;
            m_level      = 1'b0;
            m_press      = 1'b0;
            m_release    = 1'b0;
            m_toggle     = 1'b0;
            m_hold       = 1'b0;
            m_high_edges = 0;
        end else begin
            raw_hist = {raw_hist[HIST-2:0], btn_raw};
            prev     = m_level;
            if (!m_level && (&raw_hist[HIST-1:SYNC_N]))
                m_level = 1'b1;
            else if (m_level && !(|raw_hist[HIST-1:SYNC_N]))
                m_level = 1'b0;
            m_press   = m_level && !prev;
            m_release = !m_level && prev;
            if (m_press) m_toggle = !m_toggle;
            if (!m_level) m_high_edges = 0;
            else if (prev) m_high_edges++;
            m_hold = m_level && (m_high_edges >= HOLD_N);
        end
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_level", 32'(o_level), 32'(m_level));
            check("cyc_press", 32'(o_press), 32'(m_press));
            check("cyc_release", 32'(o_release), 32'(m_release));
            check("cyc_toggle", 32'(o_toggle), 32'(m_toggle));
            check("cyc_hold", 32'(o_hold), 32'(m_hold));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_level(
        input  logic want,
        input  int   limit,
        output int   n
    );
        n = 0;
        do begin
            step(1);
            n++;
        end while (o_level !== want && n < limit);
        if (o_level !== want) n = -1;
    endtask

    initial begin
        int   n;
        logic bad;
        int   segs_v [4] = '{1, 0, 1, 0};
        int   segs_l [4] = '{5, 3, 6, 2};

        reset   = 1'b1;
        btn_raw = 1'b0;
        step(10);
        check("reset_outs",
              32'({o_level, o_press, o_release, o_toggle, o_hold}), 32'd0);
        reset = 1'b0;
        step(20);
        check("idle_outs",
              32'({o_level, o_press, o_release, o_toggle, o_hold}), 32'd0);

        btn_raw = 1'b1;
        wait_level(1'b1, 30, n);
        check("press_latency", 32'(n), 32'd10);
        check("press_pulse", 32'(o_press), 32'd1);
        check("press_toggle", 32'(o_toggle), 32'd1);
        check("press_no_rel", 32'(o_release), 32'd0);
        check("model_rise", 32'(m_level), 32'd1);
        step(1);
        check("press_width", 32'(o_press), 32'd0);
        step(5);

        btn_raw = 1'b0;
        wait_level(1'b0, 30, n);
        check("release_latency", 32'(n), 32'd10);
        check("release_pulse", 32'(o_release), 32'd1);
        check("release_toggle", 32'(o_toggle), 32'd1);
        check("release_hold", 32'(o_hold), 32'd0);
        step(1);
        check("release_width", 32'(o_release), 32'd0);
        step(5);

        bad = 1'b0;
        for (int s = 0; s < 4; s++) begin
            btn_raw = segs_v[s][0];
            for (int c = 0; c < segs_l[s]; c++) begin
                step(1);
                bad = bad | o_level | o_press;
            end
        end
        check("bounce_quiet", 32'(bad), 32'd0);
        btn_raw = 1'b1;
        wait_level(1'b1, 30, n);
        check("bounce_latency", 32'(n), 32'd10);
        check("bounce_press", 32'(o_press), 32'd1);
        check("second_toggle", 32'(o_toggle), 32'd0);

        n = 0;
        while (o_hold !== 1'b1 && n < 80) begin
            step(1);
            n++;
        end
        check("hold_latency", 32'(n), 32'd32);
        check("model_hold", 32'(m_hold), 32'd1);
        step(60 - n);
        check("hold_sat", 32'({o_level, o_hold}), 32'b11);
        btn_raw = 1'b0;
        wait_level(1'b0, 30, n);
        check("hold_rel_latency", 32'(n), 32'd10);
        check("hold_drop", 32'(o_hold), 32'd0);
        step(5);

        btn_raw = 1'b1;
        step(7);
        reset = 1'b1;
        step(1);
        check("midreset_outs",
              32'({o_level, o_press, o_release, o_toggle, o_hold}), 32'd0);
        reset = 1'b0;
        wait_level(1'b1, 30, n);
        check("midreset_latency", 32'(n), 32'd10);
        check("midreset_press", 32'(o_press), 32'd1);
        check("midreset_toggle", 32'(o_toggle), 32'd1);

        for (int s = 0; s < 160; s++) begin
            int r;
            r = int'($urandom_range(0, 15));
            if (r == 0) begin
                reset   = 1'b1;
                btn_raw = 1'($urandom_range(0, 1));
                step(int'($urandom_range(1, 3)));
                reset = 1'b0;
            end else begin
                btn_raw = 1'($urandom_range(0, 1));
                if (r < 6) step(int'($urandom_range(1, 9)));
                else if (r < 14) step(int'($urandom_range(6, 30)));
                else step(int'($urandom_range(40, 70)));
            end
        end
        step(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
